// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Two-stage pipelined arithmetic unit with an opcode-selected operation set,
//   a persistent accumulator and valid/ready handshaking on both sides.
//   Stage 1 captures the operand beat, stage 2 evaluates it and holds the
//   result until the consumer takes it. One operation per cycle sustained.
//
//   Optional build macro: ALU_PIPE_SAT_EN
//     undefined : results wrap modulo 2^WIDTH, carry reports raw carry/borrow
//     defined   : ADD/DBL/ACC clamp to 2^WIDTH-1, SUB/SHR difference clamps
//                 to 0 before shifting; carry flags every clamp
//
// Parameters
//   WIDTH      operand/result width (>= 2)
//   SHIFT      logical right-shift amount used by SHR (0..WIDTH-1)
//   RESET_VAL  accumulator reset/clear value (truncated to WIDTH)
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   in_valid    in   operand beat valid
//   in_ready    out  beat accepted this cycle when in_valid is high
//   in_op       in   opcode: 0 ADD 1 SUB 2 AND 3 DBL 4 SHR 5 SEL 6 ACC 7 CLR
//   in_a        in   operand A (unsigned)
//   in_b        in   operand B (unsigned)
//   out_valid   out  result valid
//   out_ready   in   consumer accepts result
//   out_result  out  result (unsigned)
//   out_carry   out  carry / borrow / overflow flag
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH     = 4,
    parameter int SHIFT     = 2,
    parameter int RESET_VAL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_DBL = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;
    localparam logic [2:0] OP_SEL = 3'd5;
    localparam logic [2:0] OP_ACC = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    localparam logic [WIDTH-1:0] ACC_INIT = WIDTH'(RESET_VAL);

`ifdef ALU_PIPE_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    // Clamp to all-ones when the operation overflowed upward.
    function automatic logic [WIDTH-1:0] clip_high(input logic [WIDTH-1:0] raw,
                                                   input logic             ovf);
        return (SAT_ON && ovf) ? {WIDTH{1'b1}} : raw;
    endfunction

    // Clamp to zero when the subtraction borrowed.
    function automatic logic [WIDTH-1:0] clip_low(input logic [WIDTH-1:0] raw,
                                                  input logic             brw);
        return (SAT_ON && brw) ? {WIDTH{1'b0}} : raw;
    endfunction

    logic             vld_p1;
    logic [2:0]       op_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] result_p2;
    logic             carry_p2;
    logic [WIDTH-1:0] acc;

    logic             s2_free;
    logic             s1_adv;
    logic             in_fire;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH+1:0] dbl_w;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH-1:0] diff_lo;

    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic [WIDTH-1:0] acc_nxt;
    logic             acc_we;

    // Handshake: stage 1 may drain whenever stage 2 is empty or emptying.
    assign s2_free  = !vld_p2 || out_ready;
    assign s1_adv   = vld_p1 && s2_free;
    assign in_ready = !vld_p1 || s1_adv;
    assign in_fire  = in_valid && in_ready;

    // ---- stage 1: operand capture ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else if (in_fire) begin
            vld_p1 <= 1'b1;
        end else if (s1_adv) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            op_p1 <= in_op;
            a_p1  <= in_a;
            b_p1  <= in_b;
        end
    end

    // ---- stage 1 -> stage 2: evaluation ----
    assign sum_w   = {1'b0, a_p1} + {1'b0, b_p1};
    assign diff_w  = {1'b0, a_p1} - {1'b0, b_p1};
    assign dbl_w   = {sum_w, 1'b0};
    assign acc_sum = {1'b0, acc} + {1'b0, a_p1};
    assign diff_lo = clip_low(diff_w[WIDTH-1:0], diff_w[WIDTH]);

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        acc_nxt = acc;
        acc_we  = 1'b0;
        case (op_p1)
            OP_ADD: begin
                res_c   = clip_high(sum_w[WIDTH-1:0], sum_w[WIDTH]);
                carry_c = sum_w[WIDTH];
            end
            OP_SUB: begin
                res_c   = diff_lo;
                carry_c = diff_w[WIDTH];
            end
            OP_AND: begin
                res_c   = a_p1 & b_p1;
            end
            OP_DBL: begin
                // Anything at or above bit WIDTH of the doubled sum is overflow.
                carry_c = |dbl_w[WIDTH+1:WIDTH];
                res_c   = clip_high(dbl_w[WIDTH-1:0], carry_c);
            end
            OP_SHR: begin
                res_c   = diff_lo >> SHIFT;
                carry_c = diff_w[WIDTH];
            end
            OP_SEL: begin
                res_c   = (a_p1 >= b_p1) ? a_p1 : b_p1;
                carry_c = (a_p1 == b_p1);
            end
            OP_ACC: begin
                res_c   = clip_high(acc_sum[WIDTH-1:0], acc_sum[WIDTH]);
                carry_c = acc_sum[WIDTH];
                acc_nxt = res_c;
                acc_we  = 1'b1;
            end
            OP_CLR: begin
                res_c   = ACC_INIT;
                acc_nxt = ACC_INIT;
                acc_we  = 1'b1;
            end
            default: begin
                res_c   = '0;
            end
        endcase
    end

    // ---- stage 2: result hold and accumulator ----
    // The accumulator is written only when the beat moves into stage 2, so a
    // result stalled by out_ready never re-applies its update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            carry_p2  <= 1'b0;
            acc       <= ACC_INIT;
        end else if (s1_adv) begin
            vld_p2    <= 1'b1;
            result_p2 <= res_c;
            carry_p2  <= carry_c;
            if (acc_we) begin
                acc <= acc_nxt;
            end
        end else if (out_ready) begin
            vld_p2    <= 1'b0;
        end
    end

    assign out_valid  = vld_p2;
    assign out_result = result_p2;
    assign out_carry  = carry_p2;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
//   Directed, self-checking bench for alu_pipe (WIDTH=4, SHIFT=2, RESET_VAL=2).
//   A table of single-beat vectors covers every opcode and its boundaries;
//   hand-written sequences cover full-rate accumulation, backpressure,
//   a stalled ACC beat and reset with beats in flight.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 4;

`ifdef ALU_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH    (4),
        .SHIFT    (2),
        .RESET_VAL(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_carry (out_carry)
    );

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input int op, input int a, input int b,
                                input int r, input int c);
        vec_t v;
        v.op = 3'(op);
        v.a  = 4'(a);
        v.b  = 4'(b);
        v.r  = 4'(r);
        v.c  = 1'(c);
        return v;
    endfunction

    // Accepted results captured while a stream sequence runs.
    logic         collect = 1'b0;
    logic [W-1:0] got_r[$];
    logic         got_c[$];

    always @(negedge clk) begin
        #2;
        if (collect && reset && out_valid && out_ready) begin
            got_r.push_back(out_result);
            got_c.push_back(out_carry);
        end
    end

    // Per-cycle history of a stream sequence.
    logic [2:0]   s_op[4];
    logic [W-1:0] s_a[4];
    logic [W-1:0] s_b[4];
    int           acc_hist[32];
    logic         ir_hist[32];
    logic         ov_hist[32];
    logic [W-1:0] res_hist[32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Single beat with out_ready high: checks acceptance, 2-cycle latency,
    // result/carry and that the output drains.
    task automatic run_vec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] r, input logic c, input string nm);
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b1;
        #1 chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, " early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({nm, " valid"}, 32'(out_valid), 32'd1);
        chk({nm, " result"}, 32'(out_result), 32'(r));
        chk({nm, " carry"}, 32'(out_carry), 32'(c));
        @(negedge clk);
        chk({nm, " drain"}, 32'(out_valid), 32'd0);
    endtask

    // Streams n beats from s_op/s_a/s_b, holding out_ready low before cycle rdy_at.
    task automatic stream(input int n, input int rdy_at, input int cycles);
        int   idx = 0;
        logic fire;
        got_r.delete();
        got_c.delete();
        collect = 1'b1;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            acc_hist[cyc] = idx;
            ir_hist[cyc]  = in_ready;
            ov_hist[cyc]  = out_valid;
            res_hist[cyc] = out_result;
            out_ready = (cyc >= rdy_at);
            in_valid  = (idx < n);
            if (idx < n) begin
                in_op = s_op[idx];
                in_a  = s_a[idx];
                in_b  = s_b[idx];
            end
            #1 fire = in_valid && in_ready;
            @(posedge clk);
            if (fire) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #3 collect = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mk(0,  9, 8, SAT ? 15 : 1,  1);
        vecs[1]  = mk(0,  3, 4, 7,             0);
        vecs[2]  = mk(0, 15, 1, SAT ? 15 : 0,  1);
        vecs[3]  = mk(1,  3, 5, SAT ? 0 : 14,  1);
        vecs[4]  = mk(1,  9, 4, 5,             0);
        vecs[5]  = mk(2, 12, 10, 8,            0);
        vecs[6]  = mk(3,  3, 2, 10,            0);
        vecs[7]  = mk(3,  5, 4, SAT ? 15 : 2,  1);
        vecs[8]  = mk(3,  4, 4, SAT ? 15 : 0,  1);
        vecs[9]  = mk(4, 13, 1, 3,             0);
        vecs[10] = mk(4,  2, 3, SAT ? 0 : 3,   1);
        vecs[11] = mk(5,  7, 7, 7,             1);
        vecs[12] = mk(5,  3, 9, 9,             0);
        vecs[13] = mk(5, 12, 5, 12,            0);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        #3 reset  = 1'b0;
        #1;
        chk("rst out_valid",  32'(out_valid),  32'd0);
        chk("rst out_result", 32'(out_result), 32'd0);
        chk("rst out_carry",  32'(out_carry),  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst idle_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].c,
                    $sformatf("vec%0d", i));
        end

        // Full-rate accumulator chain starting from the reset value 2.
        do_reset();
        s_op[0] = 3'd6; s_a[0] = 4'd5;  s_b[0] = 4'd0;
        s_op[1] = 3'd6; s_a[1] = 4'd10; s_b[1] = 4'd0;
        s_op[2] = 3'd7; s_a[2] = 4'd0;  s_b[2] = 4'd0;
        s_op[3] = 3'd6; s_a[3] = 4'd1;  s_b[3] = 4'd0;
        stream(4, 0, 8);
        chk("acc full_rate_accepts", 32'(acc_hist[4]), 32'd4);
        for (int k = 2; k < 6; k++) begin
            chk($sformatf("acc back_to_back_valid%0d", k), 32'(ov_hist[k]), 32'd1);
        end
        chk("acc count", 32'(got_r.size()), 32'd4);
        if (got_r.size() == 4) begin
            chk("acc0 result", 32'(got_r[0]), 32'd7);
            chk("acc0 carry",  32'(got_c[0]), 32'd0);
            chk("acc1 result", 32'(got_r[1]), SAT ? 32'd15 : 32'd1);
            chk("acc1 carry",  32'(got_c[1]), 32'd1);
            chk("clr result",  32'(got_r[2]), 32'd2);
            chk("clr carry",   32'(got_c[2]), 32'd0);
            chk("acc3 result", 32'(got_r[3]), 32'd3);
            chk("acc3 carry",  32'(got_c[3]), 32'd0);
        end

        // Backpressure: consumer stalls for three cycles with a result waiting.
        for (int k = 0; k < 4; k++) begin
            s_op[k] = 3'd0;
            s_a[k]  = 4'(k + 1);
            s_b[k]  = 4'(k + 1);
        end
        stream(4, 5, 14);
        chk("bp accepts_before_stall", 32'(acc_hist[3]), 32'd2);
        chk("bp in_ready_low3", 32'(ir_hist[3]), 32'd0);
        chk("bp in_ready_low4", 32'(ir_hist[4]), 32'd0);
        chk("bp accepts_during_stall", 32'(acc_hist[5]), 32'd2);
        for (int k = 2; k < 6; k++) begin
            chk($sformatf("bp hold_valid%0d", k), 32'(ov_hist[k]), 32'd1);
            chk($sformatf("bp hold_result%0d", k), 32'(res_hist[k]), 32'd2);
        end
        chk("bp count", 32'(got_r.size()), 32'd4);
        if (got_r.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("bp result%0d", k), 32'(got_r[k]), 32'(2 * (k + 1)));
                chk($sformatf("bp carry%0d", k), 32'(got_c[k]), 32'd0);
            end
        end

        // ACC beat parked in stage 2 must update the accumulator only once.
        do_reset();
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = 3'd6;
        in_a      = 4'd1;
        in_b      = 4'd0;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall valid%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("stall result%0d", k), 32'(out_result), 32'd3);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall drained", 32'(out_valid), 32'd0);
        run_vec(3'd6, 4'd0, 4'd0, 4'd3, 1'b0, "acc_after_stall");

        // Reset with two ACC beats in flight.
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = 3'd6;
        in_a      = 4'd4;
        in_b      = 4'd0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("inflight result", 32'(out_result), 32'd7);
        reset = 1'b0;
        #1;
        chk("midrst out_valid",  32'(out_valid),  32'd0);
        chk("midrst out_result", 32'(out_result), 32'd0);
        chk("midrst in_ready",   32'(in_ready),   32'd1);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        got_r.delete();
        got_c.delete();
        collect = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        collect = 1'b0;
        chk("midrst no_stale", 32'(got_r.size()), 32'd0);
        run_vec(3'd6, 4'd0, 4'd0, 4'd2, 1'b0, "acc_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
